// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding and
// default datapath/bus geometry.
package mem_stage_pkg;

   localparam int MS_WORD_WIDTH     = 32;
   localparam int MS_REG_FILE_DEPTH = 4;
   localparam int MS_ADDR_WIDTH     = 10;
   localparam int MS_DATA_BASE      = 1024;
   localparam int MS_MAX_WAIT       = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory handshake for loads/stores,
// captures load data and freezes the upstream pipeline while waiting.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int WORD_WIDTH     = MS_WORD_WIDTH,
   parameter int REG_FILE_DEPTH = MS_REG_FILE_DEPTH,
   parameter int ADDR_WIDTH     = MS_ADDR_WIDTH,
   parameter int DATA_BASE      = MS_DATA_BASE,
   parameter int MAX_WAIT       = MS_MAX_WAIT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic                      WB_en,
   input  logic [REG_FILE_DEPTH-1:0] dst,
   input  logic [WORD_WIDTH-1:0]     ALU_res,
   input  logic [WORD_WIDTH-1:0]     st_val,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [WORD_WIDTH-1:0]     mem_wdata,
   input  logic                      mem_ready,
   input  logic [WORD_WIDTH-1:0]     mem_rdata,
   output logic                      freeze,
   output logic                      mem_err,
   output logic [REG_FILE_DEPTH-1:0] dst_out,
   output logic [WORD_WIDTH-1:0]     ALU_res_out,
   output logic [WORD_WIDTH-1:0]     mem_out,
   output logic                      mem_read_out,
   output logic                      WB_en_out
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [ADDR_WIDTH+1:0] BASE_LO = (ADDR_WIDTH + 2)'(DATA_BASE);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      wait_cnt;
   logic [WORD_WIDTH-1:0] data_q;
   logic                  err_q;
   logic                  busy;
   logic                  timeout;
   logic                  is_load;

   assign busy    = (state == BUSY);
   assign timeout = busy & ~mem_ready & (wait_cnt == CNT_W'(MAX_WAIT - 1));
   // A store wins when both strobes are set, so no load data is captured.
   assign is_load = mem_read & ~mem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= timeout;
         if (busy & ~mem_ready & ~timeout)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
         if (timeout)
            data_q <= '0;
         else if (busy & mem_ready & is_load)
            data_q <= mem_rdata;
      end
   end

   // Outputs are gated by rst so an asynchronous reset drops the request at once.
   always_comb begin
      state_nxt = state;
      freeze    = 1'b0;
      mem_req   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read | mem_write) state_nxt = BUSY;
            freeze = ~rst & (mem_read | mem_write);
         end
         BUSY: begin
            if (mem_ready | timeout) state_nxt = DONE;
            freeze  = ~rst;
            mem_req = ~rst;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Word address: byte offset from DATA_BASE with the byte-lane bits dropped.
   assign mem_addr  = ADDR_WIDTH'((ALU_res[ADDR_WIDTH+1:0] - BASE_LO) >> 2);
   assign mem_we    = mem_req & mem_write;
   assign mem_wdata = st_val;
   assign mem_err   = err_q;

   assign dst_out      = dst;
   assign ALU_res_out  = ALU_res;
   assign mem_read_out = is_load;
   assign mem_out      = data_q;
   assign WB_en_out    = WB_en & ~freeze;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load, store, timeout,
// reset mid-access and back-to-back loads.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic        WB_en;
   logic [3:0]  dst;
   logic [31:0] ALU_res;
   logic [31:0] st_val;
   logic        mem_req;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        freeze;
   logic        mem_err;
   logic [3:0]  dst_out;
   logic [31:0] ALU_res_out;
   logic [31:0] mem_out;
   logic        mem_read_out;
   logic        WB_en_out;

   int total = 0;
   int bad   = 0;
   int fcnt;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .WB_en(WB_en),
      .dst(dst), .ALU_res(ALU_res), .st_val(st_val),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .freeze(freeze), .mem_err(mem_err),
      .dst_out(dst_out), .ALU_res_out(ALU_res_out), .mem_out(mem_out),
      .mem_read_out(mem_read_out), .WB_en_out(WB_en_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; WB_en = 1'b1;
      dst = 4'd0; ALU_res = 32'h77; st_val = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_freeze", freeze, 0);
      chk("rst_mem_out", mem_out, 0);
      chk("rst_wb_en_out", WB_en_out, 1);
      @(negedge clk); rst = 1'b0;

      // ALU instruction: transparent, no freeze
      @(negedge clk); WB_en = 1'b1; ALU_res = 32'h55; dst = 4'd3; #1;
      chk("alu_freeze", freeze, 0);
      chk("alu_wb_en_out", WB_en_out, 1);
      chk("alu_res_out", ALU_res_out, 32'h55);
      chk("alu_dst_out", dst_out, 3);
      @(negedge clk); #1;
      chk("alu_freeze_next", freeze, 0);
      chk("alu_mem_req", mem_req, 0);

      // Load at 1032, ready in first BUSY cycle
      @(negedge clk); mem_read = 1'b1; ALU_res = 32'd1032; dst = 4'd5; #1;
      chk("ld_c0_freeze", freeze, 1);
      chk("ld_c0_mem_req", mem_req, 0);
      chk("ld_c0_wb", WB_en_out, 0);
      @(negedge clk); #1;
      chk("ld_c1_mem_req", mem_req, 1);
      chk("ld_c1_mem_we", mem_we, 0);
      chk("ld_c1_addr", mem_addr, 2);
      chk("ld_c1_freeze", freeze, 1);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk); mem_ready = 1'b0; mem_rdata = '0; #1;
      chk("ld_done_freeze", freeze, 0);
      chk("ld_done_mem_out", mem_out, 32'hDEADBEEF);
      chk("ld_done_wb", WB_en_out, 1);
      chk("ld_done_mem_req", mem_req, 0);
      chk("ld_done_rd_out", mem_read_out, 1);
      chk("ld_done_err", mem_err, 0);
      #1; mem_read = 1'b0; WB_en = 1'b0;

      // Store at 1024 (read also set: store wins), ready after 3 wait cycles
      @(negedge clk); mem_write = 1'b1; mem_read = 1'b1; ALU_res = 32'd1024; st_val = 32'h1234; #1;
      chk("st_c0_freeze", freeze, 1);
      chk("st_rd_out_forced", mem_read_out, 0);
      fcnt = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("st_mem_req", mem_req, 1);
         chk("st_mem_we", mem_we, 1);
         chk("st_addr", mem_addr, 0);
         chk("st_wdata", mem_wdata, 32'h1234);
         chk("st_wb", WB_en_out, 0);
         if (freeze) fcnt++;
         if (i == 3) begin mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0; end
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("st_freeze_cycles", fcnt, 5);
      chk("st_done_freeze", freeze, 0);
      chk("st_done_mem_out", mem_out, 32'hDEADBEEF);
      chk("st_done_wb", WB_en_out, 0);
      chk("st_done_mem_req", mem_req, 0);
      #1; mem_write = 1'b0; mem_read = 1'b0;

      // Load timeout: mem_ready never comes
      @(negedge clk); mem_read = 1'b1; ALU_res = 32'd1028; #1;
      fcnt = freeze ? 1 : 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); #1;
         chk("to_mem_req", mem_req, 1);
         chk("to_mem_err_low", mem_err, 0);
         if (freeze) fcnt++;
      end
      @(negedge clk); #1;
      chk("to_freeze_cycles", fcnt, 16);
      chk("to_done_mem_req", mem_req, 0);
      chk("to_done_mem_err", mem_err, 1);
      chk("to_done_mem_out", mem_out, 0);
      chk("to_done_freeze", freeze, 0);
      #1; mem_read = 1'b0;
      @(negedge clk); #1;
      chk("to_err_single", mem_err, 0);

      // Reset in second BUSY cycle, then a late mem_ready
      @(negedge clk); mem_read = 1'b1; ALU_res = 32'd1036; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("rb_mem_req_before", mem_req, 1);
      rst = 1'b1; #1;
      chk("rb_mem_req_drop", mem_req, 0);
      chk("rb_freeze_drop", freeze, 0);
      mem_read = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      chk("rb_mem_out", mem_out, 0);
      chk("rb_mem_req_idle", mem_req, 0);
      chk("rb_freeze_idle", freeze, 0);
      mem_ready = 1'b0; mem_rdata = '0;

      // Back-to-back loads at 1040 and 1044
      @(negedge clk); mem_read = 1'b1; WB_en = 1'b1; ALU_res = 32'd1040; #1;
      @(negedge clk); #1;
      chk("bb1_addr", mem_addr, 4);
      mem_ready = 1'b1; mem_rdata = 32'h11111111;
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("bb1_mem_out", mem_out, 32'h11111111);
      chk("bb1_done_req", mem_req, 0);
      #1; ALU_res = 32'd1044;
      @(negedge clk); #1;
      chk("bb2_gap_req", mem_req, 0);
      chk("bb2_idle_freeze", freeze, 1);
      chk("bb2_hold_mem_out", mem_out, 32'h11111111);
      @(negedge clk); #1;
      chk("bb2_mem_req", mem_req, 1);
      chk("bb2_addr", mem_addr, 5);
      mem_ready = 1'b1; mem_rdata = 32'h22222222;
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("bb2_mem_out", mem_out, 32'h22222222);
      chk("bb2_wb", WB_en_out, 1);
      #1; mem_read = 1'b0;
      @(negedge clk); #1;
      chk("bb_final_req", mem_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
